lms_sched: RTL

Sample-period sequencer for the complex LMS mismatch-correction datapath. It divides the system clock into fixed sample periods and issues per-phase strobes: input capture, output-product issue, error capture, update-product issue and weight accumulate. This lets a single pipelined complex multiplier be time-shared between the y = x·conj(w) and Δw = x·e products. It also owns the adaptation lifecycle: weight initialisation, training length, freeze, and step-size gear-shifting.

---
 rtl/lms_sched_pkg.sv | 20 ++
 rtl/lms_phase_gen.sv | 47 ++++
 rtl/lms_sched.sv | 101 ++++++++++
 3 files changed

// File: rtl/lms_sched_pkg.sv
// Shared types and constants for the LMS sample-period sequencer.
// Phase offsets derive from the complex multiplier latency.
package lms_sched_pkg;

   typedef enum logic [1:0] {IDLE, INIT, ADAPT, HOLD} state_t;

   localparam logic [15:0] W_INIT_RE = 16'h3FFF;
   localparam logic [15:0] W_INIT_IM = 16'h0000;

   // Error capture follows the y product out of the multiplier pipeline
   function automatic int e_ld_phase(input int mult_lat);
      return 1 + mult_lat;
   endfunction

   // The update product is issued after e_ld and needs its own pipeline drain
   function automatic int w_upd_phase(input int mult_lat);
      return 2 + 2 * mult_lat;
   endfunction

endpackage

// File: rtl/lms_phase_gen.sv
// Free-running phase counter with registered per-phase strobes.
// upd_pre is high one cycle before the weight-update slot so the top can register w_upd.
module lms_phase_gen
   import lms_sched_pkg::*;
#(
   parameter int DIV      = 8,
   parameter int MULT_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   output logic clkdv,
   output logic x_ld,
   output logic mul_sel,
   output logic e_ld,
   output logic upd_pre
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] E_PH   = PW'(e_ld_phase(MULT_LAT));
   localparam logic [PW-1:0] PRE_PH = PW'(w_upd_phase(MULT_LAT) - 1);
   localparam logic [PW-1:0] SEL_PH = PW'(MULT_LAT + 1);

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;

   // DIV is a power of two, so the increment wraps naturally
   assign phase_nxt = phase + PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= '1;
         clkdv   <= 1'b0;
         x_ld    <= 1'b0;
         mul_sel <= 1'b0;
         e_ld    <= 1'b0;
         upd_pre <= 1'b0;
      end else begin
         phase   <= phase_nxt;
         clkdv   <= phase_nxt[PW-1];
         x_ld    <= (phase_nxt == '0);
         mul_sel <= (phase_nxt > SEL_PH);
         e_ld    <= (phase_nxt == E_PH);
         upd_pre <= (phase_nxt == PRE_PH);
      end
   end

endmodule

// File: rtl/lms_sched.sv
// LMS sequencer top: adaptation FSM, update counter and step-size gearing.
// All outputs are registered from next-state so they align with the phase strobes.
module lms_sched
   import lms_sched_pkg::*;
#(
   parameter int DIV      = 8,
   parameter int MULT_LAT = 2,
   parameter int GEAR_LEN = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        freeze,
   input  logic [15:0] train_len,
   input  logic [3:0]  mu_init,
   input  logic [3:0]  mu_max,
   output logic        clkdv,
   output logic        x_ld,
   output logic        mul_sel,
   output logic        e_ld,
   output logic        w_clr,
   output logic        w_upd,
   output logic [3:0]  mu_shift,
   output logic [15:0] sample_cnt,
   output logic        busy,
   output logic        done
);

   localparam logic [15:0] GEAR_LAST = 16'(GEAR_LEN - 1);

   state_t      state;
   state_t      state_nxt;
   logic        upd_pre;
   logic        upd_nxt;
   logic [15:0] gear_cnt;

   lms_phase_gen #(
      .DIV      (DIV),
      .MULT_LAT (MULT_LAT)
   ) u_phase (
      .clk     (clk),
      .rst     (rst),
      .clkdv   (clkdv),
      .x_ld    (x_ld),
      .mul_sel (mul_sel),
      .e_ld    (e_ld),
      .upd_pre (upd_pre)
   );

   // sample_cnt already includes the update shown on w_upd, so reaching train_len ends training
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = INIT;
      end else begin
         unique case (state)
            INIT:    state_nxt = ADAPT;
            ADAPT:   if (w_upd && (train_len != 16'd0) && (sample_cnt == train_len))
                        state_nxt = HOLD;
            default: state_nxt = state;
         endcase
      end
   end

   assign upd_nxt = upd_pre && (state_nxt == ADAPT) && !freeze;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         w_clr      <= 1'b0;
         w_upd      <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         mu_shift   <= 4'd0;
         sample_cnt <= 16'd0;
         gear_cnt   <= 16'd0;
      end else begin
         state <= state_nxt;
         w_clr <= (state_nxt == INIT);
         w_upd <= upd_nxt;
         done  <= (state == ADAPT) && (state_nxt == HOLD);
         busy  <= (state_nxt == INIT) || (state_nxt == ADAPT);
         if (state_nxt == INIT) begin
            sample_cnt <= 16'd0;
            gear_cnt   <= 16'd0;
            mu_shift   <= mu_init;
         end else if (upd_nxt) begin
            sample_cnt <= sample_cnt + 16'd1;
            if (gear_cnt == GEAR_LAST) begin
               gear_cnt <= 16'd0;
               // A mu_init above mu_max simply stays where it started
               if (mu_shift < mu_max)
                  mu_shift <= mu_shift + 4'd1;
            end else begin
               gear_cnt <= gear_cnt + 16'd1;
            end
         end
      end
   end

endmodule
